// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the configurable UART receiver.
package uart_pkg;

   localparam int DEF_NB_DATA    = 8;
   localparam int DEF_OVERSAMPLE = 16;

   // Run-time parity selection; 2'b11 is not listed and behaves as none.
   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } par_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   // True when the frame carries a parity bit.
   function automatic logic par_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to idle (1).
module uart_sync2 (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   // Two-stage capture; both stages preload 1 so reset never looks like a start bit.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_meta <= 1'b1;
         r_q    <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled frame FSM, run-time parity,
// framing/break detection and a one-deep holding register with overrun flag.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int NB_DATA    = DEF_NB_DATA,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int NB_STOP    = 1,
   parameter int NB_TCNT    = 5
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic               i_rx,
   input  logic [1:0]         i_parity_mode,
   input  logic               i_rx_read,
   output logic [NB_DATA-1:0] o_rx_data,
   output logic               o_rx_valid,
   output logic               o_rx_done,
   output logic               o_parity_err,
   output logic               o_frame_err,
   output logic               o_overrun
);

   localparam int NB_BIT = $clog2(NB_DATA);

   localparam logic [NB_TCNT-1:0] C_HALF = NB_TCNT'(OVERSAMPLE / 2 - 1);
   localparam logic [NB_TCNT-1:0] C_BIT  = NB_TCNT'(OVERSAMPLE - 1);
   localparam logic [NB_TCNT-1:0] C_STOP = NB_TCNT'(NB_STOP * OVERSAMPLE - 1);
   localparam logic [NB_BIT-1:0]  C_LAST = NB_BIT'(NB_DATA - 1);

   logic                w_rxs;

   rx_state_e           r_state,  w_state_nx;
   logic [NB_TCNT-1:0]  r_cnt,    w_cnt_nx;
   logic [NB_BIT-1:0]   r_bit,    w_bit_nx;
   logic [NB_DATA-1:0]  r_shift,  w_shift_nx;
   logic [1:0]          r_mode,   w_mode_nx;
   logic                r_perr,   w_perr_nx;
   logic                r_ferr,   w_ferr_nx;
   logic                r_brk,    w_brk_nx;
   logic                w_commit;
   logic [NB_TCNT-1:0]  w_cnt_inc;

   uart_sync2 u_sync (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_d     (i_rx),
      .o_q     (w_rxs)
   );

   assign w_cnt_inc = r_cnt + NB_TCNT'(1);

   // Frame state and datapath registers.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_mode  <= PAR_NONE;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_brk   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_bit   <= w_bit_nx;
         r_shift <= w_shift_nx;
         r_mode  <= w_mode_nx;
         r_perr  <= w_perr_nx;
         r_ferr  <= w_ferr_nx;
         r_brk   <= w_brk_nx;
      end
   end

   // Next-state logic; everything except start detection advances on i_tick only.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_bit_nx   = r_bit;
      w_shift_nx = r_shift;
      w_mode_nx  = r_mode;
      w_perr_nx  = r_perr;
      w_ferr_nx  = r_ferr;
      w_brk_nx   = r_brk;
      w_commit   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // After a break the line must go high before a new start is armed.
            if (w_rxs) begin
               w_brk_nx = 1'b0;
            end else if (!r_brk) begin
               w_state_nx = ST_START;
               w_cnt_nx   = '0;
               w_mode_nx  = i_parity_mode;
               w_perr_nx  = 1'b0;
               w_ferr_nx  = 1'b0;
            end
         end

         ST_START: begin
            if (i_tick) begin
               if (r_cnt == C_HALF) begin
                  // Mid start bit: still low means a real start, else a glitch.
                  if (!w_rxs) begin
                     w_state_nx = ST_DATA;
                     w_cnt_nx   = '0;
                     w_bit_nx   = '0;
                  end else begin
                     w_state_nx = ST_IDLE;
                  end
               end else begin
                  w_cnt_nx = w_cnt_inc;
               end
            end
         end

         ST_DATA: begin
            if (i_tick) begin
               if (r_cnt == C_BIT) begin
                  w_shift_nx = {w_rxs, r_shift[NB_DATA-1:1]};
                  w_cnt_nx   = '0;
                  if (r_bit == C_LAST) begin
                     w_state_nx = par_enabled(r_mode) ? ST_PARITY : ST_STOP;
                  end else begin
                     w_bit_nx = r_bit + NB_BIT'(1);
                  end
               end else begin
                  w_cnt_nx = w_cnt_inc;
               end
            end
         end

         ST_PARITY: begin
            if (i_tick) begin
               if (r_cnt == C_BIT) begin
                  w_perr_nx  = ((^r_shift) ^ w_rxs) != (r_mode == PAR_ODD);
                  w_state_nx = ST_STOP;
                  w_cnt_nx   = '0;
               end else begin
                  w_cnt_nx = w_cnt_inc;
               end
            end
         end

         ST_STOP: begin
            if (i_tick) begin
               // Sample at the middle of every stop bit.
               if (((r_cnt == C_BIT) || (r_cnt == C_STOP)) && !w_rxs)
                  w_ferr_nx = 1'b1;
               if (r_cnt == C_STOP) begin
                  // Commit half-way through the last stop bit so the next start edge is caught.
                  w_state_nx = ST_IDLE;
                  w_cnt_nx   = '0;
                  w_commit   = 1'b1;
                  w_brk_nx   = w_ferr_nx & ~w_rxs;
               end else begin
                  w_cnt_nx = w_cnt_inc;
               end
            end
         end

         default: begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
         end
      endcase
   end

   // Holding register: commit has priority over the consumer pop.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         o_rx_data    <= '0;
         o_rx_valid   <= 1'b0;
         o_rx_done    <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         o_rx_done <= w_commit;
         if (w_commit) begin
            o_rx_data    <= r_shift;
            o_parity_err <= r_perr;
            o_frame_err  <= w_ferr_nx;
            o_rx_valid   <= 1'b1;
            if (o_rx_valid && !i_rx_read)
               o_overrun <= 1'b1;
         end else if (i_rx_read && o_rx_valid) begin
            o_rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: default 8-bit/1-stop instance plus a
// 7-bit/2-stop instance, random and directed frames against a frame-level model.
module tb_uart_rx_cfg;

   localparam int OS     = 16;
   localparam int TDIV   = 4;
   localparam int BITCLK = OS * TDIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       rx1 = 1'b1, rx2 = 1'b1;
   logic       rd1 = 1'b0, rd2 = 1'b0, rd_coin = 1'b0;
   logic       rd1_w;
   logic [1:0] pmode = 2'b00;
   int         tdiv_cnt = 0;

   logic [7:0] o_data1;
   logic       o_valid1, o_done1, o_perr1, o_ferr1, o_ovr1;
   logic [6:0] o_data2;
   logic       o_valid2, o_done2, o_perr2, o_ferr2, o_ovr2;

   typedef struct {
      logic [8:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   // Tick every TDIV clocks.
   always @(posedge clk) begin
      tdiv_cnt <= (tdiv_cnt == TDIV - 1) ? 0 : tdiv_cnt + 1;
      tick     <= (tdiv_cnt == TDIV - 2);
   end

   // Read pulse aligned with the second commit for the no-overrun case.
   assign rd1_w = rd1 | (rd_coin & u_dut.w_commit);

   uart_rx_cfg u_dut (
      .i_clock       (clk),
      .i_reset       (rst_n),
      .i_tick        (tick),
      .i_rx          (rx1),
      .i_parity_mode (pmode),
      .i_rx_read     (rd1_w),
      .o_rx_data     (o_data1),
      .o_rx_valid    (o_valid1),
      .o_rx_done     (o_done1),
      .o_parity_err  (o_perr1),
      .o_frame_err   (o_ferr1),
      .o_overrun     (o_ovr1)
   );

   uart_rx_cfg #(.NB_DATA(7), .OVERSAMPLE(OS), .NB_STOP(2), .NB_TCNT(5)) u_dut7 (
      .i_clock       (clk),
      .i_reset       (rst_n),
      .i_tick        (tick),
      .i_rx          (rx2),
      .i_parity_mode (pmode),
      .i_rx_read     (rd2),
      .o_rx_data     (o_data2),
      .o_rx_valid    (o_valid2),
      .o_rx_done     (o_done2),
      .o_parity_err  (o_perr2),
      .o_frame_err   (o_ferr2),
      .o_overrun     (o_ovr2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitors: every completed frame must match the oldest expected frame.
   always @(negedge clk) begin
      if (o_done1) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL d1_unexpected_done actual=%h required=no_frame", o_data1);
         end else begin
            e1 = q1.pop_front();
            chk("d1_data", 32'(o_data1), 32'(e1.d));
            chk("d1_perr", 32'(o_perr1), 32'(e1.pe));
            chk("d1_ferr", 32'(o_ferr1), 32'(e1.fe));
            chk("d1_valid", 32'(o_valid1), 32'd1);
         end
      end
   end

   always @(negedge clk) begin
      if (o_done2) begin
         if (q2.size() == 0) begin
            total++; bad++;
            $display("FAIL d2_unexpected_done actual=%h required=no_frame", o_data2);
         end else begin
            e2 = q2.pop_front();
            chk("d2_data", 32'(o_data2), 32'(e2.d));
            chk("d2_perr", 32'(o_perr2), 32'(e2.pe));
            chk("d2_ferr", 32'(o_ferr2), 32'(e2.fe));
            chk("d2_valid", 32'(o_valid2), 32'd1);
         end
      end
   end

   task automatic line(input int d, input logic b, input int nclk);
      if (d == 1) rx1 = b; else rx2 = b;
      repeat (nclk) @(negedge clk);
   endtask

   // Drive one frame and queue what a correct receiver must report for it.
   task automatic send(input int d, input int nb, input logic [8:0] data,
                       input logic flip, input logic stop0, input int nstop);
      logic [8:0] m;
      logic       par;
      exp_t       e;
      m = data & ((9'h1 << nb) - 9'h1);
      e.d  = m;
      e.pe = (pmode == 2'b01 || pmode == 2'b10) ? flip : 1'b0;
      e.fe = ~stop0;
      if (d == 1) q1.push_back(e); else q2.push_back(e);
      line(d, 1'b0, BITCLK);
      for (int i = 0; i < nb; i++) line(d, m[i], BITCLK);
      if (pmode == 2'b01 || pmode == 2'b10) begin
         par = 1'b0;
         for (int i = 0; i < nb; i++) par = par ^ m[i];
         if (pmode == 2'b10) par = ~par;
         line(d, par ^ flip, BITCLK);
      end
      line(d, stop0, BITCLK);
      for (int i = 1; i < nstop; i++) line(d, 1'b1, BITCLK);
   endtask

   // Consumer pop: holding register must be full, then empty with data held.
   task automatic pop(input int d, input logic [8:0] expd);
      if (d == 1) begin
         chk("d1_full_before_read", 32'(o_valid1), 32'd1);
         rd1 = 1'b1; @(negedge clk); rd1 = 1'b0; @(negedge clk);
         chk("d1_empty_after_read", 32'(o_valid1), 32'd0);
         chk("d1_data_held", 32'(o_data1), 32'(expd));
      end else begin
         chk("d2_full_before_read", 32'(o_valid2), 32'd1);
         rd2 = 1'b1; @(negedge clk); rd2 = 1'b0; @(negedge clk);
         chk("d2_empty_after_read", 32'(o_valid2), 32'd0);
         chk("d2_data_held", 32'(o_data2), 32'(expd));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [8:0] rd;
      logic       fl, st;

      // Reset state
      repeat (5) @(negedge clk);
      chk("rst_d1_data", 32'(o_data1), 32'd0);
      chk("rst_d1_valid", 32'(o_valid1), 32'd0);
      chk("rst_d1_done", 32'(o_done1), 32'd0);
      chk("rst_d1_errs", {30'd0, o_perr1, o_ferr1}, 32'd0);
      chk("rst_d1_ovr", 32'(o_ovr1), 32'd0);
      chk("rst_d2_all", {o_data2, o_valid2, o_done2, o_perr2, o_ferr2, o_ovr2}, 32'd0);
      rst_n = 1'b1;
      line(1, 1'b1, BITCLK);

      // Plain 8N1
      pmode = 2'b00;
      send(1, 8, 9'h0CC, 1'b0, 1'b1, 1);
      line(1, 1'b1, BITCLK);
      pop(1, 9'h0CC);

      // Parity: even good/bad, odd good
      pmode = 2'b01;
      send(1, 8, 9'h0A5, 1'b0, 1'b1, 1); line(1, 1'b1, BITCLK); pop(1, 9'h0A5);
      send(1, 8, 9'h0A5, 1'b1, 1'b1, 1); line(1, 1'b1, BITCLK);
      chk("even_bad_perr_held", 32'(o_perr1), 32'd1);
      pop(1, 9'h0A5);
      pmode = 2'b10;
      send(1, 8, 9'h001, 1'b0, 1'b1, 1); line(1, 1'b1, BITCLK); pop(1, 9'h001);

      // Framing error followed by a held break: only one frame reported
      pmode = 2'b00;
      send(1, 8, 9'h03C, 1'b0, 1'b0, 1);
      line(1, 1'b0, 3 * 10 * BITCLK);
      line(1, 1'b1, 2 * BITCLK);
      chk("break_ferr_held", 32'(o_ferr1), 32'd1);
      pop(1, 9'h03C);

      // Short glitch is ignored; a following clean frame still arrives
      line(1, 1'b0, 5 * TDIV);
      line(1, 1'b1, 2 * BITCLK);
      chk("glitch_no_frame", 32'(o_valid1), 32'd0);
      send(1, 8, 9'h05A, 1'b0, 1'b1, 1); line(1, 1'b1, BITCLK); pop(1, 9'h05A);

      // Random frames, parity modes (incl. 2'b11) and stop errors
      repeat (8) begin
         pmode = 2'($urandom_range(0, 3));
         rd    = 9'($urandom_range(0, 255));
         fl    = 1'($urandom_range(0, 1));
         st    = ($urandom_range(0, 3) != 0);
         send(1, 8, rd, fl, st, 1);
         line(1, 1'b1, BITCLK);
         pop(1, rd);
      end

      // Overrun: two back-to-back frames without a read
      pmode = 2'b00;
      chk("ovr_clear_before", 32'(o_ovr1), 32'd0);
      send(1, 8, 9'h011, 1'b0, 1'b1, 1);
      send(1, 8, 9'h022, 1'b0, 1'b1, 1);
      line(1, 1'b1, BITCLK);
      chk("ovr_set", 32'(o_ovr1), 32'd1);
      chk("ovr_data_newest", 32'(o_data1), 32'h22);
      do_reset();
      chk("ovr_cleared_by_reset", 32'(o_ovr1), 32'd0);
      chk("valid_cleared_by_reset", 32'(o_valid1), 32'd0);

      // Read coincident with the second commit: no overrun, still full
      line(1, 1'b1, BITCLK);
      send(1, 8, 9'h011, 1'b0, 1'b1, 1);
      rd_coin = 1'b1;
      send(1, 8, 9'h022, 1'b0, 1'b1, 1);
      rd_coin = 1'b0;
      line(1, 1'b1, BITCLK);
      chk("coin_no_ovr", 32'(o_ovr1), 32'd0);
      pop(1, 9'h022);

      // 7 data bits, 2 stop bits
      send(2, 7, 9'h055, 1'b0, 1'b1, 2); line(2, 1'b1, BITCLK); pop(2, 9'h055);
      send(2, 7, 9'h033, 1'b0, 1'b0, 2); line(2, 1'b1, BITCLK); pop(2, 9'h033);

      // Reset in the middle of the data bits aborts the frame
      line(2, 1'b0, BITCLK);
      line(2, 1'b1, BITCLK);
      line(2, 1'b0, BITCLK);
      line(2, 1'b1, BITCLK / 2);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rx2 = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_d2_outputs", {o_data2, o_valid2, o_perr2, o_ferr2, o_ovr2}, 32'd0);
      line(2, 1'b1, 2 * BITCLK);
      chk("midrst_no_frame", 32'(o_valid2), 32'd0);
      send(2, 7, 9'h02A, 1'b0, 1'b1, 2); line(2, 1'b1, BITCLK); pop(2, 9'h02A);

      chk("d1_all_frames_seen", 32'(q1.size()), 32'd0);
      chk("d2_all_frames_seen", 32'(q2.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor to the fixed 8N1 UART receiver. Takes the serial line plus the oversampling tick from the baud rate generator. Data width, oversampling ratio and stop-bit count are set at elaboration; parity mode is selected at run time. Adds a metastability synchroniser, start-bit glitch rejection, parity/framing error flags and a one-deep holding register with read handshake and overrun detection; sits between the pad and the ALU interface FSM.

Parameters:
NB_DATA, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, i_tick pulses per bit period (even, >=8)
NB_STOP, 1, stop bits checked (1 or 2)
NB_TCNT, 5, tick counter width; must hold NB_STOP*OVERSAMPLE-1

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous, active-low reset (0 = reset)
i_tick  in  1  oversampling enable, 1-cycle pulse, OVERSAMPLE per bit
i_rx  in  1  asynchronous serial line, idle high
i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
i_rx_read  in  1  consumer pop of holding register
o_rx_data  out  NB_DATA  holding register contents
o_rx_valid  out  1  holding register full
o_rx_done  out  1  1-cycle pulse when a frame is written to holding register
o_parity_err  out  1  parity error of frame in holding register
o_frame_err  out  1  stop-bit error of frame in holding register
o_overrun  out  1  sticky; a frame arrived while o_rx_valid=1 and no read

Behaviour:
- Reset (i_reset=0 at clock edge): FSM IDLE, counters 0, shift reg 0, synchroniser loaded with 1s; all outputs 0. Reset mid-frame aborts the frame, nothing written.
- i_rx passes through 2 flops; "rxs" below is the synchronised value (2 cycles latency).
- FSM state changes and counter updates only on cycles with i_tick=1, except IDLE->START (any cycle, rxs=0).
- IDLE: rxs=0 -> START, tick cnt=0; latch i_parity_mode into mode_q (held for whole frame).
- START: on tick, cnt==OVERSAMPLE/2-1: rxs=0 -> DATA, cnt=0, bit=0; rxs=1 -> IDLE (glitch, no flags). Otherwise cnt++.
- DATA: on tick, cnt==OVERSAMPLE-1: shift rxs into MSB of NB_DATA shift reg (LSB first on line), cnt=0, bit++; after bit NB_DATA-1 -> PARITY if mode_q in {01,10}, else STOP. Otherwise cnt++.
- PARITY: sample at cnt==OVERSAMPLE-1; perr = (^data ^ sampled) != (mode_q==10). -> STOP, cnt=0.
- STOP: sample at cnt==OVERSAMPLE-1 of each stop bit (cnt runs 0..NB_STOP*OVERSAMPLE-1); any sample 0 sets ferr. After last stop sample -> IDLE and commit in the same cycle. Receiver is back in IDLE mid-stop-bit, so back-to-back frames are accepted.
- Commit: o_rx_data<=shift, o_parity_err<=perr, o_frame_err<=ferr, o_rx_valid<=1, o_rx_done=1 for exactly one cycle. Frames with errors are still committed.
- Overrun: commit while o_rx_valid=1 and i_rx_read=0 -> new frame overwrites register, o_overrun<=1. Commit with i_rx_read=1 in same cycle -> no overrun, o_rx_valid stays 1.
- i_rx_read with o_rx_valid=1 and no commit -> o_rx_valid<=0 next cycle; data/flags hold. Read while empty is ignored.
- o_overrun clears only on reset.
- Break (line held 0): frame_err=1, data=0; FSM waits in IDLE for rxs=1 before next START (a break_wait flag set on ferr with rxs=0).

Decomposition:
- Shared package/include uart_pkg: parity mode encodings (PAR_NONE/EVEN/ODD), FSM state encodings, default NB_DATA/OVERSAMPLE.
- One natural sub-module: uart_sync2 (2-flop synchroniser with reset value 1). Holding register and FSM stay in uart_rx_cfg.

Test Plan:
- Defaults, parity none, tick every 4 clocks, send 0xCC 8N1 from existing transmitter -> one o_rx_done, o_rx_data=0xCC, valid=1, both errors 0.
- Even parity, frame 0xA5 with parity bit 0 -> data 0xA5, parity_err 0; same frame with parity bit 1 -> parity_err 1. Odd mode, 0x01 with parity bit 0 -> parity_err 0.
- 0x3C with stop bit driven 0 -> frame_err 1, data 0x3C; then line held 0 for 3 frame times -> no further o_rx_done until line returns high.
- 0-pulse of 5 ticks (< OVERSAMPLE/2) on idle line -> no o_rx_done, FSM back in IDLE.
- Two back-to-back frames 0x11, 0x22, no i_rx_read -> o_overrun 1, o_rx_data 0x22; repeat with read pulse coincident with second commit -> o_overrun stays 0.
- NB_DATA=7, NB_STOP=2, 0x55 -> data 0x55; i_reset=0 in mid DATA -> outputs 0, next clean frame 0x2A received correctly.
